// File: rtl/ddr2_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ddr2_arbiter_pkg : shared DDR2 command encodings, arbiter states, defaults
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ddr2_arbiter_pkg;

  localparam int ADDR_BITS_DEF = 13;
  localparam int BA_BITS_DEF   = 3;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ddr2_cmd_mux.sv
// ---------------------------------------------------------------------------
// ddr2_cmd_mux : registered init/refresh/write/read mux onto the DDR2 command bus
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ddr2_cmd_mux
  import ddr2_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int BA_BITS   = BA_BITS_DEF
) (
  input  logic                 ck,
  input  logic                 rst,
  input  state_t               state,
  input  logic                 force_nop,
  input  logic [3:0]           init_cmd,
  input  logic [BA_BITS-1:0]   init_ba,
  input  logic [ADDR_BITS-1:0] init_addr,
  input  logic [3:0]           aref_cmd,
  input  logic [ADDR_BITS-1:0] aref_addr,
  input  logic [3:0]           wr_cmd,
  input  logic [BA_BITS-1:0]   wr_ba,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [3:0]           rd_cmd,
  input  logic [BA_BITS-1:0]   rd_ba,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [3:0]           ddr_cmd,
  output logic [BA_BITS-1:0]   ddr_ba,
  output logic [ADDR_BITS-1:0] ddr_addr
);

  // Bank and address hold their last value whenever a NOP is issued.
  always_ff @(posedge ck) begin
    if (rst) begin
      ddr_cmd  <= CMD_NOP;
      ddr_ba   <= '0;
      ddr_addr <= '0;
    end else if (force_nop) begin
      ddr_cmd <= CMD_NOP;
    end else begin
      unique case (state)
        ST_IDLE: begin
          ddr_cmd  <= init_cmd;
          ddr_ba   <= init_ba;
          ddr_addr <= init_addr;
        end
        ST_AREF: begin
          ddr_cmd  <= aref_cmd;
          ddr_ba   <= '0;
          ddr_addr <= aref_addr;
        end
        ST_WRITE: begin
          ddr_cmd  <= wr_cmd;
          ddr_ba   <= wr_ba;
          ddr_addr <= wr_addr;
        end
        ST_READ: begin
          ddr_cmd  <= rd_cmd;
          ddr_ba   <= rd_ba;
          ddr_addr <= rd_addr;
        end
        default: ddr_cmd <= CMD_NOP;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ddr2_arbiter.sv
// ---------------------------------------------------------------------------
// ddr2_arbiter : fixed-priority refresh/write/read arbiter with grant pulses,
//                burst-break hints and a granted-state watchdog
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ddr2_arbiter
  import ddr2_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int BA_BITS   = BA_BITS_DEF,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 init_end,
  input  logic [3:0]           init_cmd,
  input  logic [BA_BITS-1:0]   init_ba,
  input  logic [ADDR_BITS-1:0] init_addr,
  input  logic                 aref_req,
  output logic                 aref_en,
  input  logic [3:0]           aref_cmd,
  input  logic [ADDR_BITS-1:0] aref_addr,
  input  logic                 aref_end,
  input  logic                 wr_req,
  output logic                 wr_en,
  input  logic [3:0]           wr_cmd,
  input  logic [BA_BITS-1:0]   wr_ba,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic                 wr_end,
  output logic                 wr_break,
  input  logic                 rd_req,
  output logic                 rd_en,
  input  logic [3:0]           rd_cmd,
  input  logic [BA_BITS-1:0]   rd_ba,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic                 rd_end,
  output logic                 rd_break,
  output logic [3:0]           ddr_cmd,
  output logic [BA_BITS-1:0]   ddr_ba,
  output logic [ADDR_BITS-1:0] ddr_addr,
  output logic                 timeout_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic             granted;
  logic             cur_end;
  logic             tmo_hit;

  always_comb begin
    granted = 1'b0;
    cur_end = 1'b0;
    unique case (state)
      ST_AREF:  begin granted = 1'b1; cur_end = aref_end; end
      ST_WRITE: begin granted = 1'b1; cur_end = wr_end;   end
      ST_READ:  begin granted = 1'b1; cur_end = rd_end;   end
      default:  ;
    endcase
  end

  // An end in the last allowed cycle takes precedence over the watchdog.
  assign tmo_hit = granted && (tmo_cnt == TMO_LAST) && !cur_end;

  always_ff @(posedge ck) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (init_end) state_next = ST_ARBIT;
      ST_ARBIT: begin
        if (aref_req)    state_next = ST_AREF;
        else if (wr_req) state_next = ST_WRITE;
        else if (rd_req) state_next = ST_READ;
      end
      ST_AREF, ST_WRITE, ST_READ: if (cur_end || tmo_hit) state_next = ST_ARBIT;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      aref_en     <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      wr_break    <= 1'b0;
      rd_break    <= 1'b0;
      timeout_err <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      aref_en  <= (state == ST_ARBIT) && (state_next == ST_AREF);
      wr_en    <= (state == ST_ARBIT) && (state_next == ST_WRITE);
      rd_en    <= (state == ST_ARBIT) && (state_next == ST_READ);
      // Break follows the state being entered so it drops with the end edge.
      wr_break <= (state_next == ST_WRITE) && aref_req;
      rd_break <= (state_next == ST_READ) && aref_req;
      if (tmo_hit) timeout_err <= 1'b1;
      if (state == ST_ARBIT) tmo_cnt <= '0;
      else if (granted)      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  ddr2_cmd_mux #(
    .ADDR_BITS (ADDR_BITS),
    .BA_BITS   (BA_BITS)
  ) u_cmd_mux (
    .ck        (ck),
    .rst       (rst),
    .state     (state),
    .force_nop (tmo_hit),
    .init_cmd  (init_cmd),
    .init_ba   (init_ba),
    .init_addr (init_addr),
    .aref_cmd  (aref_cmd),
    .aref_addr (aref_addr),
    .wr_cmd    (wr_cmd),
    .wr_ba     (wr_ba),
    .wr_addr   (wr_addr),
    .rd_cmd    (rd_cmd),
    .rd_ba     (rd_ba),
    .rd_addr   (rd_addr),
    .ddr_cmd   (ddr_cmd),
    .ddr_ba    (ddr_ba),
    .ddr_addr  (ddr_addr)
  );

endmodule

`default_nettype wire

// File: doc/ddr2_arbiter.md
Name: ddr2_arbiter

Overview:
- Grant-side counterpart of the refresh, write and read request/enable/end handshakes.
- Holds off all traffic until initialisation completes.
- Arbitrates refresh, write and read requests with fixed priority and returns one-cycle enable pulses.
- Muxes the winning source's command, bank and address onto the registered DDR2 command bus; sits between the init/refresh/write/read engines and the PHY pins.

Parameters:
- ADDR_BITS, 13, row/column address width (matches `ADDR_BITS`).
- BA_BITS, 3, bank address width (matches `BA_BITS`).
- TIMEOUT, 1024, max cycles in a granted state before forced return to ARBIT.

Ports:
- ck  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- init_end  in  1  level; initialisation complete.
- init_cmd  in  4  init engine command {cs_n,ras_n,cas_n,we_n}.
- init_ba  in  BA_BITS  init bank address.
- init_addr  in  ADDR_BITS  init address.
- aref_req  in  1  refresh request (level until aref_en seen).
- aref_en  out  1  refresh grant pulse.
- aref_cmd  in  4  refresh command.
- aref_addr  in  ADDR_BITS  refresh address (A10 for precharge-all).
- aref_end  in  1  refresh sequence done.
- wr_req  in  1  write request.
- wr_en  out  1  write grant pulse.
- wr_cmd  in  4  write engine command.
- wr_ba  in  BA_BITS  write engine bank.
- wr_addr  in  ADDR_BITS  write engine address.
- wr_end  in  1  write done.
- wr_break  out  1  refresh pending; write engine must terminate at next burst boundary.
- rd_req  in  1  read request.
- rd_en  out  1  read grant pulse.
- rd_cmd  in  4  read engine command.
- rd_ba  in  BA_BITS  read engine bank.
- rd_addr  in  ADDR_BITS  read engine address.
- rd_end  in  1  read done.
- rd_break  out  1  refresh pending; read engine must terminate at next burst boundary.
- ddr_cmd  out  4  registered DDR2 command.
- ddr_ba  out  BA_BITS  registered bank address.
- ddr_addr  out  ADDR_BITS  registered address.
- timeout_err  out  1  sticky; a granted state timed out.

Behaviour:
- Clocking/reset: one clock ck. rst is synchronous, active-high, and overrides everything.
- Reset values: state=IDLE; aref_en, wr_en, rd_en, wr_break, rd_break, timeout_err=0; ddr_cmd=NOP (4'b0111); ddr_ba=0; ddr_addr=0; timeout counter=0.
- States: IDLE, ARBIT, AREF, WRITE, READ.
- IDLE:
  - ddr_* follows init_* with a 1-cycle register delay.
  - All requests are ignored.
  - init_end=1 -> ARBIT.
- ARBIT:
  - ddr_cmd=NOP.
  - Priority is aref_req > wr_req > rd_req.
  - On the edge that moves ARBIT->X, the matching x_en registers to 1. It is high for exactly one cycle, then 0.
  - No request -> stay in ARBIT.
- AREF / WRITE / READ:
  - ddr_cmd/ba/addr <= the granted source's cmd/ba/addr, 1-cycle latency.
  - In AREF, ddr_ba is forced to 0.
  - x_end=1 -> ARBIT on that edge.
  - A new grant cannot occur on the same edge as an end, so ARBIT lasts at least 1 cycle between grants.
- Break: wr_break = registered (state==WRITE && aref_req); rd_break likewise for READ. Both are 0 in all other states. The arbiter itself never aborts a grant.
- Timeout:
  - The counter clears on entering a granted state and increments each cycle in it.
  - When it reaches TIMEOUT-1 with no end: go to ARBIT, set timeout_err=1 (held until rst), drive ddr_cmd=NOP.
  - If end and timeout occur in the same cycle, end wins and timeout_err is not set.
- init_end deasserting outside IDLE: ignored (init_end is a level that stays high once set).
- Requests dropping before grant: simply not granted. A request already granted is not re-granted until its end plus one ARBIT cycle.
- Reset mid-operation: immediate return to the reset values. Re-entry to ARBIT requires init_end=1, one cycle after rst deasserts.

Decomposition:
- Shared package/define file holds:
  - command encodings NOP=4'b0111, PRE=4'b0010, AREF=4'b0001, ACT, WR, RD;
  - the state encoding;
  - ADDR_BITS/BA_BITS defaults.
- One natural sub-module, ddr2_cmd_mux: the registered 3-way + init mux for ddr_cmd/ba/addr, selected by state.
- FSM, grant pulses, break and timeout logic stay in ddr2_arbiter.

Test Plan:
- Reset/init hold: rst=1 for 5 cycles, then init_end=0 with init_cmd=PRE, wr_req=1.
  - Required: ddr_cmd=PRE one cycle later, wr_en never asserted.
  - Then set init_end=1: wr_en pulses exactly 1 cycle, no earlier than 2 cycles after init_end.
- Priority: aref_req, wr_req, rd_req all asserted in ARBIT.
  - Required: aref_en pulses first and ddr_ba=0 throughout AREF.
  - After aref_end: ≥1 ARBIT cycle with ddr_cmd=NOP, then wr_en.
- Break: in WRITE, raise aref_req.
  - Required: wr_break=1 on the next cycle.
  - Assert wr_end: state→ARBIT, wr_break=0, aref_en on the following grant.
- Mux latency: in READ, drive rd_cmd=4'b0101, rd_ba=3, rd_addr=13'h0400.
  - Required: ddr_cmd/ba/addr show those values exactly 1 cycle later.
- Timeout: TIMEOUT=16, grant write, never assert wr_end.
  - Required: return to ARBIT after 16 cycles, timeout_err=1, held until rst.
  - Repeat with wr_end in cycle 16: timeout_err stays 0.
- Reset mid-op: assert rst during AREF.
  - Required: next cycle all outputs at reset values.
  - After rst release with init_end=1: ARBIT, and the still-asserted aref_req is re-granted.
